// File: rtl/band_filter_pkg.sv
// Shared constants, default coefficients and scheduler state encoding for the
// time-multiplexed band filter.
package band_filter_pkg;

  localparam int NUM_BANDS = 4;
  localparam int SAMPLE_W  = 8;
  localparam int STATE_W   = 16;
  localparam int COEF_W    = 8;
  localparam int SHIFT     = 8;
  localparam int PROD_W    = COEF_W + STATE_W;
  localparam int SUM_W     = STATE_W + 2;

  localparam logic [1:0] LAST_BAND = 2'(NUM_BANDS - 1);

  // Entry [b] holds the coefficient of band b.
  localparam logic [NUM_BANDS-1:0][COEF_W-1:0] DEF_A = {8'd5, 8'd10, 8'd15, 8'd20};
  localparam logic [NUM_BANDS-1:0][COEF_W-1:0] DEF_B = {8'd40, 8'd30, 8'd25, 8'd10};

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_B,
    WRITE
  } state_t;

endpackage

// File: rtl/band_filter_scheduler_mac.sv
// Shared signed multiply-shift plus saturating state update used by every band.
module band_mac_unit
  import band_filter_pkg::*;
(
  input  logic signed [COEF_W-1:0]  coef,
  input  logic signed [STATE_W-1:0] operand,
  input  logic signed [STATE_W-1:0] state_in,
  input  logic signed [STATE_W-1:0] p_a,
  output logic signed [STATE_W-1:0] product,
  output logic signed [STATE_W-1:0] next_state
);

  localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-STATE_W+1){1'b0}}, {(STATE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-STATE_W+1){1'b1}}, {(STATE_W-1){1'b0}}};

  logic signed [PROD_W-1:0] full;
  logic signed [SUM_W-1:0]  sum;

  always_comb begin
    full    = coef * operand;
    product = STATE_W'(full >>> SHIFT);
    // Product is treated as p_b here; in the MUL_A cycle next_state is ignored.
    sum = SUM_W'(state_in) - SUM_W'(p_a) + SUM_W'(product);
    if (sum > MAX_S) begin
      next_state = MAX_S[STATE_W-1:0];
    end else if (sum < MIN_S) begin
      next_state = MIN_S[STATE_W-1:0];
    end else begin
      next_state = sum[STATE_W-1:0];
    end
  end

endmodule

// File: rtl/band_filter_scheduler.sv
// Sequences the four IIR bands through one shared multiplier per sample strobe
// and holds the runtime-writable A/B coefficients and per-band filter state.
module band_filter_scheduler
  import band_filter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_strobe,
  input  logic [SAMPLE_W-1:0] audio_sample,
  input  logic                clear,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  output logic                cfg_ready,
  output logic                busy,
  output logic                res_valid,
  output logic [1:0]          res_band,
  output logic [STATE_W-1:0]  res_value,
  output logic                done,
  output logic                overrun
);

  state_t                     state;
  logic [1:0]                 band;
  logic signed [SAMPLE_W-1:0] x;
  logic signed [STATE_W-1:0]  p_a;
  logic signed [COEF_W-1:0]   coef_a [NUM_BANDS];
  logic signed [COEF_W-1:0]   coef_b [NUM_BANDS];
  logic signed [STATE_W-1:0]  s      [NUM_BANDS];
  logic signed [STATE_W-1:0]  y      [NUM_BANDS];

  logic signed [COEF_W-1:0]   mac_coef;
  logic signed [STATE_W-1:0]  mac_operand;
  logic signed [STATE_W-1:0]  mac_product;
  logic signed [STATE_W-1:0]  mac_next;

  always_comb begin
    if (state == MUL_A) begin
      mac_coef    = coef_a[band];
      mac_operand = y[band];
    end else begin
      mac_coef    = coef_b[band];
      mac_operand = STATE_W'(x);
    end
  end

  band_mac_unit u_mac (
    .coef       (mac_coef),
    .operand    (mac_operand),
    .state_in   (s[band]),
    .p_a        (p_a),
    .product    (mac_product),
    .next_state (mac_next)
  );

  assign cfg_ready = ~busy;

  // The state update and result register are loaded at the end of MUL_B so the
  // registered result pulse is visible during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      band      <= '0;
      x         <= '0;
      p_a       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_band  <= '0;
      res_value <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) begin
        s[i]      <= '0;
        y[i]      <= '0;
        coef_a[i] <= DEF_A[i];
        coef_b[i] <= DEF_B[i];
      end
    end else begin
      if (cfg_we && !busy) begin
        if (cfg_addr[0]) coef_b[cfg_addr[2:1]] <= cfg_data;
        else             coef_a[cfg_addr[2:1]] <= cfg_data;
      end

      if (clear) begin
        state     <= IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
        done      <= 1'b0;
        overrun   <= 1'b0;
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
          s[i] <= '0;
          y[i] <= '0;
        end
      end else begin
        res_valid <= 1'b0;
        done      <= 1'b0;
        if (sample_strobe && state != IDLE) overrun <= 1'b1;

        case (state)
          IDLE: begin
            if (sample_strobe) begin
              x     <= audio_sample;
              band  <= '0;
              busy  <= 1'b1;
              state <= MUL_A;
            end
          end
          MUL_A: begin
            p_a   <= mac_product;
            state <= MUL_B;
          end
          MUL_B: begin
            y[band]   <= s[band];
            s[band]   <= mac_next;
            res_valid <= 1'b1;
            res_band  <= band;
            res_value <= mac_next;
            done      <= (band == LAST_BAND);
            state     <= WRITE;
          end
          WRITE: begin
            if (band == LAST_BAND) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              band  <= band + 2'd1;
              state <= MUL_A;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_band_filter_scheduler.sv
// Directed bench for band_filter_scheduler with a per-sequence arithmetic model
// checked against the DUT outputs every cycle.
module tb_band_filter_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_strobe;
  logic [7:0]  audio_sample;
  logic        clear;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_ready;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_band;
  logic [15:0] res_value;
  logic        done;
  logic        overrun;

  band_filter_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .audio_sample  (audio_sample),
    .clear         (clear),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_band      (res_band),
    .res_value     (res_value),
    .done          (done),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit started = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a whole sequence is evaluated when a strobe is accepted; coefficient
  // writes cannot land mid-sequence and clear/rst wipe all state, so this is exact.
  typedef struct {
    int due;
    int band;
    int val;
  } res_t;

  res_t pend[$];
  int ma[4], mb[4], ms[4], my[4];
  int last_acc = -1000;
  bit m_ovr = 0;
  int lv_band = 0, lv_val = 0;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    bit   mbusy;
    int   xv, pa, pb, n;
    res_t r;
    mbusy = (cyc > last_acc) && (cyc <= last_acc + 12);
    if (rst) begin
      ma = '{20, 15, 10, 5};
      mb = '{10, 25, 30, 40};
      ms = '{0, 0, 0, 0};
      my = '{0, 0, 0, 0};
      pend.delete();
      last_acc = -1000;
      m_ovr = 0;
      lv_band = 0;
      lv_val = 0;
      started = 1;
    end else begin
      if (cfg_we && !mbusy) begin
        if (cfg_addr[0]) mb[cfg_addr[2:1]] = int'($signed(cfg_data));
        else             ma[cfg_addr[2:1]] = int'($signed(cfg_data));
      end
      if (clear) begin
        ms = '{0, 0, 0, 0};
        my = '{0, 0, 0, 0};
        pend.delete();
        last_acc = -1000;
        m_ovr = 0;
      end else if (sample_strobe) begin
        if (mbusy) begin
          m_ovr = 1;
        end else begin
          last_acc = cyc;
          xv = int'($signed(audio_sample));
          for (int b = 0; b < 4; b++) begin
            pa = (ma[b] * my[b]) >>> 8;
            pb = (mb[b] * xv) >>> 8;
            n  = sat16(ms[b] - pa + pb);
            my[b] = ms[b];
            ms[b] = n;
            r.due = cyc + 3 * b + 3;
            r.band = b;
            r.val = n;
            pend.push_back(r);
          end
        end
      end
    end
    cyc++;
  end

  int obs[4];
  int res_cnt = 0;
  int done_cyc = -1;

  always @(negedge clk) begin
    bit ev, eb;
    if (started) begin
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      if (ev) begin
        lv_band = pend[0].band;
        lv_val  = pend[0].val;
        void'(pend.pop_front());
      end
      eb = (cyc > last_acc) && (cyc <= last_acc + 12);
      check("res_valid", int'(res_valid), int'(ev));
      check("done", int'(done), int'(ev && lv_band == 3));
      check("busy", int'(busy), int'(eb));
      check("cfg_ready", int'(cfg_ready), int'(!eb));
      check("overrun", int'(overrun), int'(m_ovr));
      check("res_band", int'(res_band), lv_band);
      check("res_value", int'($signed(res_value)), lv_val);
      if (res_valid) begin
        obs[res_band] = int'($signed(res_value));
        res_cnt++;
      end
      if (done) done_cyc = cyc;
    end
  end

  int s0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] v);
    s0 = cyc;
    sample_strobe = 1'b1;
    audio_sample  = v;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic expect_defaults_64(input string tag);
    check({tag, "_b0"}, obs[0], 2);
    check({tag, "_b1"}, obs[1], 6);
    check({tag, "_b2"}, obs[2], 7);
    check({tag, "_b3"}, obs[3], 10);
  endtask

  initial begin
    int rc;
    rst = 1'b1;
    sample_strobe = 1'b0;
    audio_sample = '0;
    clear = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_cfg_ready", int'(cfg_ready), 1);
    check("reset_res_value", int'(res_value), 0);
    tick(2);

    // Single x = 64 after reset
    strobe(8'd64);
    tick(14);
    expect_defaults_64("single64");
    check("done_latency", done_cyc - s0, 12);

    // Three strobes of 64, 20 cycles apart, band 0 accumulates
    pulse_clear();
    strobe(8'd64); tick(19);
    check("triple_1", obs[0], 2);
    strobe(8'd64); tick(19);
    check("triple_2", obs[0], 4);
    strobe(8'd64); tick(19);
    check("triple_3", obs[0], 6);

    // Negative full-scale input
    pulse_clear();
    strobe(8'h80);
    tick(14);
    check("neg_b0", obs[0], -5);
    check("neg_b3", obs[3], -20);

    // Saturation: band 0 A = 0, B = 127, back-to-back strobes every 13 cycles
    pulse_clear();
    cfg_write(3'b000, 8'd0);
    cfg_write(3'b001, 8'd127);
    strobe(8'd127);
    tick(12);
    check("sat_first", obs[0], 63);
    strobe(8'd127);
    tick(12);
    check("sat_second", obs[0], 126);
    for (int i = 0; i < 528; i++) begin
      strobe(8'd127);
      tick(12);
    end
    tick(2);
    check("sat_hold", obs[0], 32767);

    // Overrun, dropped cfg write while busy, clear
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    strobe(8'd64);
    tick(3);
    cfg_write(3'b001, 8'd0);
    strobe(8'd99);
    tick(10);
    expect_defaults_64("ovr_seq");
    check("overrun_set", int'(overrun), 1);
    strobe(8'd64);
    tick(14);
    check("dropped_cfg_b0", obs[0], 4);
    pulse_clear();
    check("overrun_clear", int'(overrun), 0);

    // rst mid-sequence after altering a coefficient
    cfg_write(3'b111, 8'd0);
    tick(1);
    strobe(8'd64);
    tick(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    rc = res_cnt;
    tick(15);
    check("rst_no_results", res_cnt, rc);
    strobe(8'd64);
    tick(14);
    expect_defaults_64("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
